// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared base encodings, feeder state enum and default widths for the Smith-Waterman front end.
package sw_pkg;

    localparam logic [1:0] BASE_A = 2'b00;
    localparam logic [1:0] BASE_C = 2'b01;
    localparam logic [1:0] BASE_G = 2'b10;
    localparam logic [1:0] BASE_T = 2'b11;

    localparam int SCORE_WIDTH_DEFAULT = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PAD,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } feeder_state_e;

endpackage

// File: rtl/sw_onehot_dec.sv
// rtl/sw_onehot_dec.sv - binary PE index to one-hot store select, all zero when not enabled.
module sw_onehot_dec #(
    parameter int N = 64,
    parameter int W = 7
) (
    input  logic [W-1:0] idx,
    input  logic         en,
    output logic [N-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            onehot[i] = en && (idx == W'(i));
        end
    end

endmodule

// File: rtl/sw_array_feeder.sv
// rtl/sw_array_feeder.sv - loads read bases into the PE chain, streams reference bases, flushes with bubbles.
// SW_FEEDER_STATS_EN adds ref_count / bubble_count outputs.
module sw_array_feeder
    import sw_pkg::*;
#(
    parameter int NUM_PE      = 64,
    parameter int SCORE_WIDTH = sw_pkg::SCORE_WIDTH_DEFAULT,
    parameter int LEN_WIDTH   = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             rd_base,
    input  logic                   rd_valid,
    input  logic                   rd_last,
    output logic                   rd_ready,
    input  logic [1:0]             ref_base,
    input  logic                   ref_valid,
    input  logic                   ref_last,
    output logic                   ref_ready,
    output logic [1:0]             S_out,
    output logic [NUM_PE-1:0]      store_sel,
    output logic [1:0]             T_out,
    output logic                   init_out,
    output logic [SCORE_WIDTH-1:0] V_out,
    output logic [SCORE_WIDTH-1:0] F_out,
    output logic [LEN_WIDTH-1:0]   read_len,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
`ifdef SW_FEEDER_STATS_EN
    ,
    output logic [31:0]            ref_count,
    output logic [31:0]            bubble_count
`endif
);

    localparam logic [LEN_WIDTH-1:0] ONE        = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0] PE_CNT     = LEN_WIDTH'(NUM_PE);
    localparam logic [LEN_WIDTH-1:0] PE_LAST    = LEN_WIDTH'(NUM_PE - 1);
    localparam logic [LEN_WIDTH-1:0] DRAIN_LAST = (NUM_PE > 1) ? LEN_WIDTH'(NUM_PE - 2) : '0;

    feeder_state_e          state_q, state_d;
    logic [LEN_WIDTH-1:0]   k_q, k_d;
    logic [LEN_WIDTH-1:0]   read_len_q, read_len_d;
    logic                   overflow_q, overflow_d;
    logic [1:0]             s_q, s_d;
    logic [1:0]             t_q, t_d;
    logic                   init_q, init_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [NUM_PE-1:0]      store_sel_q, store_sel_d;
    logic                   store_en;
    logic                   rd_acc, ref_acc;

    assign rd_ready  = (state_q == ST_LOAD);
    assign ref_ready = (state_q == ST_STREAM);
    assign rd_acc    = rd_valid && rd_ready;
    assign ref_acc   = ref_valid && ref_ready;

    sw_onehot_dec #(
        .N (NUM_PE),
        .W (LEN_WIDTH)
    ) u_store_dec (
        .idx    (k_q),
        .en     (store_en),
        .onehot (store_sel_d)
    );

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        read_len_d = read_len_q;
        overflow_d = overflow_q;
        s_d        = s_q;
        t_d        = t_q;
        init_d     = 1'b0;
        store_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_LOAD;
                    k_d        = '0;
                    read_len_d = '0;
                    overflow_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (rd_acc) begin
                    if (k_q == PE_CNT) begin
                        // chain already full: swallow the beat so the source can reach rd_last
                        overflow_d = 1'b1;
                        if (rd_last) state_d = ST_STREAM;
                    end else begin
                        store_en   = 1'b1;
                        s_d        = rd_base;
                        k_d        = k_q + ONE;
                        read_len_d = read_len_q + ONE;
                        if (rd_last) state_d = (k_q < PE_LAST) ? ST_PAD : ST_STREAM;
                    end
                end
            end
            ST_PAD: begin
                store_en = 1'b1;
                s_d      = BASE_A;
                k_d      = k_q + ONE;
                if (k_q == PE_LAST) state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (ref_acc) begin
                    t_d    = ref_base;
                    init_d = 1'b1;
                    if (ref_last) begin
                        k_d     = '0;
                        state_d = (NUM_PE > 1) ? ST_DRAIN : ST_DONE;
                    end
                end
            end
            ST_DRAIN: begin
                if (k_q == DRAIN_LAST) state_d = ST_DONE;
                else                   k_d     = k_q + ONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            read_len_q  <= '0;
            overflow_q  <= 1'b0;
            s_q         <= '0;
            t_q         <= '0;
            init_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            store_sel_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            read_len_q  <= read_len_d;
            overflow_q  <= overflow_d;
            s_q         <= s_d;
            t_q         <= t_d;
            init_q      <= init_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            store_sel_q <= store_sel_d;
        end
    end

    assign S_out     = s_q;
    assign store_sel = store_sel_q;
    assign T_out     = t_q;
    assign init_out  = init_q;
    assign V_out     = '0;
    assign F_out     = '0;
    assign read_len  = read_len_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = overflow_q;

`ifdef SW_FEEDER_STATS_EN
    logic [31:0] ref_count_q, ref_count_d;
    logic [31:0] bubble_count_q, bubble_count_d;

    always_comb begin
        ref_count_d    = ref_count_q;
        bubble_count_d = bubble_count_q;
        if (state_q == ST_IDLE && start) begin
            ref_count_d    = '0;
            bubble_count_d = '0;
        end else if (state_q == ST_STREAM) begin
            if (ref_acc) ref_count_d    = ref_count_q + 32'd1;
            else         bubble_count_d = bubble_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_count_q    <= '0;
            bubble_count_q <= '0;
        end else begin
            ref_count_q    <= ref_count_d;
            bubble_count_q <= bubble_count_d;
        end
    end

    assign ref_count    = ref_count_q;
    assign bubble_count = bubble_count_q;
`endif

endmodule
